// File: rtl/flash_sample_sequencer_pkg.sv
// Purpose : shared types and defaults for the flash audio sample sequencer.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: sequencer state enum, address-width/region defaults, 16-bit signed sample type.
package flash_seq_pkg;

    localparam int ADDR_W_DEF = 23;
    localparam logic [22:0] FIRST_ADDR_DEF = 23'h000000;
    localparam logic [22:0] LAST_ADDR_DEF  = 23'h07FFFF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        SAMP0   = 3'd2,
        SAMP1   = 3'd3,
        ADVANCE = 3'd4
    } state_t;

    typedef logic signed [15:0] sample_t;

endpackage

// File: rtl/flash_sample_sequencer_addr_wrap_counter.sv
// Purpose : loadable up/down word-address counter with inclusive wrap bounds [FIRST, LAST].
// Latency : count updates on the edge after en/load_first/load_last.
// Backpressure: none; loads take priority over counting, load_first over load_last.
// Ports: clk, reset (sync, active-high), en (step), up (1 = +1, 0 = -1),
//        load_first / load_last (jump to a bound), count (current address).
module addr_wrap_counter #(
    parameter int           W     = 23,
    parameter logic [W-1:0] FIRST = '0,
    parameter logic [W-1:0] LAST  = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         up,
    input  logic         load_first,
    input  logic         load_last,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= FIRST;
        end else if (load_first) begin
            count <= FIRST;
        end else if (load_last) begin
            count <= LAST;
        end else if (en) begin
            if (up) begin
                count <= (count == LAST) ? FIRST : count + ONE;
            end else begin
                count <= (count == FIRST) ? LAST : count - ONE;
            end
        end
    end

endmodule

// File: rtl/flash_sample_sequencer.sv
// Purpose : fetches 32-bit words from flash via the read FSM and plays them out as two 16-bit samples.
// Latency : sample_valid/audio_sample one cycle after a qualifying sample_tick; fsm_stim drops the cycle after read_done.
// Backpressure: fsm_stim is a level held until read_done; ticks arriving while no word is ready are dropped.
// Ports: clk, reset (sync, active-high), sample_tick, play_en, direction, restart, read_done, flash_data
//        -> fsm_stim, flash_addr, audio_sample, sample_valid [, rd_timeout].
// Optional: define FLASH_SEQ_TIMEOUT_EN to add the REQ watchdog (TIMEOUT_CYCLES) and the sticky rd_timeout port.
module flash_sample_sequencer
    import flash_seq_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] FIRST_ADDR = FIRST_ADDR_DEF,
    parameter logic [ADDR_W-1:0] LAST_ADDR  = LAST_ADDR_DEF
`ifdef FLASH_SEQ_TIMEOUT_EN
    , parameter int              TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_tick,
    input  logic              play_en,
    input  logic              direction,
    input  logic              restart,
    input  logic              read_done,
    input  logic [31:0]       flash_data,
    output logic              fsm_stim,
    output logic [ADDR_W-1:0] flash_addr,
    output sample_t           audio_sample,
    output logic              sample_valid
`ifdef FLASH_SEQ_TIMEOUT_EN
    , output logic            rd_timeout
`endif
);

    state_t      state;
    logic [31:0] word;
    logic        word_fwd;      // direction captured with the word; fixes half order and advance sense
    logic        restart_pend;  // restart seen during REQ, applied when the read completes
    logic        restart_fwd;   // direction sampled with the pending restart

    logic        do_restart;
    logic        restart_to_first;
    logic        adv_en;
    logic        lock;          // blocks leaving IDLE after a watchdog error
    logic        timeout_hit;

    always_comb begin
        do_restart       = 1'b0;
        restart_to_first = direction;
        adv_en           = 1'b0;
        case (state)
            REQ: begin
                // A restart during REQ never aborts the handshake; it lands on read_done.
                if (read_done && (restart || restart_pend)) begin
                    do_restart       = 1'b1;
                    restart_to_first = restart ? direction : restart_fwd;
                end
            end
            ADVANCE: begin
                do_restart = restart;
                adv_en     = !restart;
            end
            default: do_restart = restart;
        endcase
    end

    addr_wrap_counter #(
        .W     (ADDR_W),
        .FIRST (FIRST_ADDR),
        .LAST  (LAST_ADDR)
    ) u_addr (
        .clk        (clk),
        .reset      (reset),
        .en         (adv_en),
        .up         (word_fwd),
        .load_first (do_restart && restart_to_first),
        .load_last  (do_restart && !restart_to_first),
        .count      (flash_addr)
    );

`ifdef FLASH_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;

    // Counts cycles spent in REQ; hits on the TIMEOUT_CYCLES-th edge without read_done.
    assign timeout_hit = (state == REQ) && !read_done && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign lock        = rd_timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt     <= '0;
            rd_timeout <= 1'b0;
        end else begin
            if (state != REQ || read_done) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            if (timeout_hit) begin
                rd_timeout <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign lock        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            fsm_stim     <= 1'b0;
            audio_sample <= '0;
            sample_valid <= 1'b0;
            word         <= '0;
            word_fwd     <= 1'b1;
            restart_pend <= 1'b0;
            restart_fwd  <= 1'b1;
        end else begin
            sample_valid <= 1'b0;
            if (do_restart) begin
                // Address reload happens in the counter; the latched word is dropped here.
                word         <= '0;
                restart_pend <= 1'b0;
                if (play_en && !lock) begin
                    state    <= REQ;
                    fsm_stim <= 1'b1;
                end else begin
                    state    <= IDLE;
                    fsm_stim <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (play_en && !lock) begin
                            state    <= REQ;
                            fsm_stim <= 1'b1;
                        end
                    end
                    REQ: begin
                        if (read_done) begin
                            word     <= flash_data;
                            word_fwd <= direction;
                            fsm_stim <= 1'b0;
                            state    <= SAMP0;
                        end else if (timeout_hit) begin
                            fsm_stim     <= 1'b0;
                            restart_pend <= 1'b0;
                            state        <= IDLE;
                        end else if (restart) begin
                            restart_pend <= 1'b1;
                            restart_fwd  <= direction;
                        end
                    end
                    SAMP0: begin
                        if (sample_tick && play_en) begin
                            audio_sample <= word_fwd ? sample_t'(word[15:0]) : sample_t'(word[31:16]);
                            sample_valid <= 1'b1;
                            state        <= SAMP1;
                        end
                    end
                    SAMP1: begin
                        if (sample_tick && play_en) begin
                            audio_sample <= word_fwd ? sample_t'(word[31:16]) : sample_t'(word[15:0]);
                            sample_valid <= 1'b1;
                            state        <= ADVANCE;
                        end
                    end
                    ADVANCE: begin
                        if (play_en && !lock) begin
                            state    <= REQ;
                            fsm_stim <= 1'b1;
                        end else begin
                            state    <= IDLE;
                            fsm_stim <= 1'b0;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        fsm_stim <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_flash_sample_sequencer.sv
// Purpose : directed, table-driven bench for flash_sample_sequencer (play, pause, restart, wrap, reset, watchdog).
// Latency : each vector is one clock; outputs are sampled 1 time unit after the rising edge.
// Backpressure: the bench plays the flash FSM, returning read_done only when a vector asks for it.
module tb_flash_sample_sequencer;
    import flash_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_tick;
    logic        play_en;
    logic        direction;
    logic        restart;
    logic        read_done;
    logic [31:0] flash_data;
    logic        fsm_stim;
    logic [22:0] flash_addr;
    sample_t     audio_sample;
    logic        sample_valid;
`ifdef FLASH_SEQ_TIMEOUT_EN
    logic        rd_timeout;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    flash_sample_sequencer #(
        .ADDR_W     (23),
        .FIRST_ADDR (23'h000000),
        .LAST_ADDR  (23'h07FFFF)
`ifdef FLASH_SEQ_TIMEOUT_EN
        , .TIMEOUT_CYCLES (16)
`endif
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_tick  (sample_tick),
        .play_en      (play_en),
        .direction    (direction),
        .restart      (restart),
        .read_done    (read_done),
        .flash_data   (flash_data),
        .fsm_stim     (fsm_stim),
        .flash_addr   (flash_addr),
        .audio_sample (audio_sample),
        .sample_valid (sample_valid)
`ifdef FLASH_SEQ_TIMEOUT_EN
        , .rd_timeout (rd_timeout)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pe;
        logic        dir;
        logic        rs;
        logic        tk;
        logic        rd;
        logic [31:0] data;
        logic        stim;
        logic [22:0] addr;
        logic [15:0] smp;
        logic        vld;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic pe, input logic dir, input logic rs, input logic tk,
                                input logic rd, input logic [31:0] data, input logic stim,
                                input logic [22:0] addr, input logic [15:0] smp, input logic vld);
        vec_t v;
        v.pe = pe; v.dir = dir; v.rs = rs; v.tk = tk; v.rd = rd; v.data = data;
        v.stim = stim; v.addr = addr; v.smp = smp; v.vld = vld;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pe, input logic dir, input logic rs, input logic tk,
                         input logic rd, input logic [31:0] data);
        play_en     = pe;
        direction   = dir;
        restart     = rs;
        sample_tick = tk;
        read_done   = rd;
        flash_data  = data;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic stim, input logic [22:0] addr,
                              input logic [15:0] smp, input logic vld);
        check({tag, ".fsm_stim"},     {31'h0, fsm_stim},         {31'h0, stim});
        check({tag, ".flash_addr"},   {9'h0, flash_addr},        {9'h0, addr});
        check({tag, ".audio_sample"}, {16'h0, audio_sample},     {16'h0, smp});
        check({tag, ".sample_valid"}, {31'h0, sample_valid},     {31'h0, vld});
    endtask

    initial begin
        int n;

        //            pe dir rs tk rd data           stim addr        smp       vld
        vt.push_back(mk(1, 1, 0, 0, 0, 32'h0,         1, 23'h000000, 16'h0000, 0)); // IDLE -> REQ
        vt.push_back(mk(1, 1, 0, 0, 0, 32'h0,         1, 23'h000000, 16'h0000, 0)); // REQ holds level
        vt.push_back(mk(1, 1, 0, 0, 1, 32'hBBBB_AAAA, 0, 23'h000000, 16'h0000, 0)); // word latched
        vt.push_back(mk(1, 1, 0, 1, 0, 32'h0,         0, 23'h000000, 16'hAAAA, 1)); // low half first
        vt.push_back(mk(1, 1, 0, 0, 0, 32'h0,         0, 23'h000000, 16'hAAAA, 0));
        vt.push_back(mk(1, 1, 0, 1, 0, 32'h0,         0, 23'h000000, 16'hBBBB, 1)); // high half
        vt.push_back(mk(1, 1, 0, 0, 0, 32'h0,         1, 23'h000001, 16'hBBBB, 0)); // advance, re-request
        vt.push_back(mk(1, 1, 0, 1, 0, 32'h0,         1, 23'h000001, 16'hBBBB, 0)); // tick in REQ dropped
        vt.push_back(mk(1, 1, 0, 0, 1, 32'hCAFE_F00D, 0, 23'h000001, 16'hBBBB, 0));
        vt.push_back(mk(1, 1, 0, 1, 0, 32'h0,         0, 23'h000001, 16'hF00D, 1));
        vt.push_back(mk(0, 1, 0, 1, 0, 32'h0,         0, 23'h000001, 16'hF00D, 0)); // paused tick ignored
        vt.push_back(mk(0, 1, 0, 1, 0, 32'h0,         0, 23'h000001, 16'hF00D, 0));
        vt.push_back(mk(1, 1, 0, 1, 0, 32'h0,         0, 23'h000001, 16'hCAFE, 1)); // resume: second half
        vt.push_back(mk(1, 1, 0, 0, 0, 32'h0,         1, 23'h000002, 16'hCAFE, 0));
        vt.push_back(mk(1, 1, 1, 0, 0, 32'h0,         1, 23'h000002, 16'hCAFE, 0)); // restart in REQ: pending
        vt.push_back(mk(1, 1, 0, 0, 0, 32'h0,         1, 23'h000002, 16'hCAFE, 0));
        vt.push_back(mk(1, 1, 0, 0, 1, 32'hDEAD_BEEF, 1, 23'h000000, 16'hCAFE, 0)); // word discarded, new REQ
        vt.push_back(mk(1, 1, 0, 1, 0, 32'h0,         1, 23'h000000, 16'hCAFE, 0));
        vt.push_back(mk(1, 1, 0, 0, 1, 32'h1111_2222, 0, 23'h000000, 16'hCAFE, 0));
        vt.push_back(mk(1, 1, 0, 1, 0, 32'h0,         0, 23'h000000, 16'h2222, 1));
        vt.push_back(mk(1, 0, 1, 1, 0, 32'h0,         1, 23'h07FFFF, 16'h2222, 0)); // restart beats tick
        vt.push_back(mk(1, 0, 0, 0, 1, 32'h1234_5678, 0, 23'h07FFFF, 16'h2222, 0));
        vt.push_back(mk(1, 0, 0, 1, 0, 32'h0,         0, 23'h07FFFF, 16'h1234, 1)); // backward: high half first
        vt.push_back(mk(1, 0, 0, 1, 0, 32'h0,         0, 23'h07FFFF, 16'h5678, 1));
        vt.push_back(mk(1, 0, 0, 0, 0, 32'h0,         1, 23'h07FFFE, 16'h5678, 0)); // address decrements
        vt.push_back(mk(1, 1, 1, 0, 1, 32'h0,         1, 23'h000000, 16'h5678, 0)); // restart + read_done
        vt.push_back(mk(1, 0, 0, 0, 1, 32'hABCD_0123, 0, 23'h000000, 16'h5678, 0));
        vt.push_back(mk(1, 0, 0, 1, 0, 32'h0,         0, 23'h000000, 16'hABCD, 1));
        vt.push_back(mk(1, 1, 0, 1, 0, 32'h0,         0, 23'h000000, 16'h0123, 1)); // dir flip has no effect yet
        vt.push_back(mk(1, 1, 0, 0, 0, 32'h0,         1, 23'h07FFFF, 16'h0123, 0)); // wrap FIRST -> LAST
        vt.push_back(mk(1, 1, 0, 0, 1, 32'h0000_FFFF, 0, 23'h07FFFF, 16'h0123, 0));
        vt.push_back(mk(1, 1, 0, 1, 0, 32'h0,         0, 23'h07FFFF, 16'hFFFF, 1));
        vt.push_back(mk(1, 1, 0, 1, 0, 32'h0,         0, 23'h07FFFF, 16'h0000, 1));
        vt.push_back(mk(0, 1, 0, 0, 0, 32'h0,         0, 23'h000000, 16'h0000, 0)); // wrap LAST -> FIRST, IDLE
        vt.push_back(mk(0, 1, 0, 0, 0, 32'h0,         0, 23'h000000, 16'h0000, 0));
        vt.push_back(mk(0, 1, 0, 0, 1, 32'hFFFF_FFFF, 0, 23'h000000, 16'h0000, 0)); // read_done in IDLE ignored
        vt.push_back(mk(1, 1, 0, 0, 0, 32'h0,         1, 23'h000000, 16'h0000, 0));

        reset       = 1'b1;
        play_en     = 1'b0;
        direction   = 1'b1;
        restart     = 1'b0;
        sample_tick = 1'b0;
        read_done   = 1'b0;
        flash_data  = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        expect_out("reset", 1'b0, 23'h0, 16'h0, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].pe, vt[i].dir, vt[i].rs, vt[i].tk, vt[i].rd, vt[i].data);
            expect_out($sformatf("vec%0d", i), vt[i].stim, vt[i].addr, vt[i].smp, vt[i].vld);
        end

        // Build up non-reset state, then reset in the middle of a REQ.
        drive(1, 1, 0, 0, 1, 32'h5555_7777);
        drive(1, 1, 0, 1, 0, 32'h0);
        drive(1, 1, 0, 1, 0, 32'h0);
        drive(1, 1, 0, 0, 0, 32'h0);
        expect_out("pre_reset", 1'b1, 23'h000001, 16'h5555, 1'b0);
        reset = 1'b1;
        drive(1, 1, 0, 0, 0, 32'h0);
        expect_out("mid_req_reset", 1'b0, 23'h0, 16'h0, 1'b0);
        reset = 1'b0;
        drive(0, 1, 0, 0, 0, 32'h0);
        expect_out("post_reset_idle", 1'b0, 23'h0, 16'h0, 1'b0);

        // Stalled read: the flash FSM never answers.
        drive(1, 1, 0, 0, 0, 32'h0);
        check("stall_req_entered", {31'h0, fsm_stim}, 32'h1);
        n = 0;
        while (fsm_stim && n < 40) begin
            drive(1, 1, 0, 0, 0, 32'h0);
            n++;
        end
`ifdef FLASH_SEQ_TIMEOUT_EN
        check("timeout_cycles", n, 32'd16);
        check("timeout_flag", {31'h0, rd_timeout}, 32'h1);
        for (int k = 0; k < 6; k++) begin
            drive(1, 1, 0, 0, 0, 32'h0);
            check($sformatf("timeout_hold_stim%0d", k), {31'h0, fsm_stim}, 32'h0);
            check($sformatf("timeout_hold_flag%0d", k), {31'h0, rd_timeout}, 32'h1);
        end
        reset = 1'b1;
        drive(1, 1, 0, 0, 0, 32'h0);
        reset = 1'b0;
        check("timeout_cleared", {31'h0, rd_timeout}, 32'h0);
`else
        check("stall_waits", n, 32'd40);
        check("stall_stim_high", {31'h0, fsm_stim}, 32'h1);
        drive(1, 1, 0, 0, 1, 32'h0000_4321);
        check("stall_released", {31'h0, fsm_stim}, 32'h0);
        drive(1, 1, 0, 1, 0, 32'h0);
        check("stall_sample", {16'h0, audio_sample}, 32'h0000_4321);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/flash_sample_sequencer.md
Name: flash_sample_sequencer

Overview:
- Sits directly upstream of the flash read FSM (`fsm`) and consumes its output.
- Issues one word read per request on `fsm_stim` and drives the word address to flash.
- Captures the 32-bit word returned when the read completes, splits it into two 16-bit audio samples and presents them on successive `sample_tick` strobes.
- Supports forward/backward play, pause and restart, with address wrap-around at both ends.

Parameters:
ADDR_W, 23, width of flash word address.
FIRST_ADDR, 23'h000000, first word address of the audio region.
LAST_ADDR, 23'h07FFFF, last word address of the audio region (inclusive).
TIMEOUT_CYCLES, 1024, read watchdog limit; used only with FLASH_SEQ_TIMEOUT_EN.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
reset  in  1  synchronous, active-high reset.
sample_tick  in  1  one-cycle strobe at the audio sample rate, from the clock divider.
play_en  in  1  1 = play, 0 = pause.
direction  in  1  1 = forward, 0 = backward.
restart  in  1  one-cycle pulse; jump to the start of the region for the current direction.
read_done  in  1  one-cycle pulse from the flash FSM when `flash_mem_readdatavalid` is captured.
flash_data  in  32  read data; valid in the same cycle as `read_done`.
fsm_stim  out  1  read request level to the flash FSM.
flash_addr  out  ADDR_W  word address for the current read.
audio_sample  out  16  current output sample (two's complement).
sample_valid  out  1  one-cycle pulse when `audio_sample` updates.
rd_timeout  out  1  sticky watchdog error; exists only with FLASH_SEQ_TIMEOUT_EN.

Behaviour:
- Reset values: `fsm_stim`=0, `flash_addr`=FIRST_ADDR, `audio_sample`=0, `sample_valid`=0, `rd_timeout`=0, state=IDLE, word register=0.
- Reset applied mid-read drops `fsm_stim` on the next edge. No outstanding read is tracked.
- States: IDLE, REQ, SAMP0, SAMP1, ADVANCE.
- IDLE: `fsm_stim`=0. Go to REQ when `play_en`=1.
- REQ:
  - `fsm_stim`=1, held as a level, never pulsed.
  - On `read_done`: latch `flash_data` and `direction` into internal registers; `fsm_stim`=0 from the next cycle; go to SAMP0.
  - `read_done` outside REQ is ignored.
- SAMP0: on `sample_tick` with `play_en`=1:
  - forward: `audio_sample` ← word[15:0];
  - backward: `audio_sample` ← word[31:16];
  - `sample_valid`=1 on the following cycle (latency 1 from the tick); go to SAMP1.
- SAMP1: on the next qualifying tick, output the other half with the same latency; go to ADVANCE.
- ADVANCE (one cycle):
  - forward: `flash_addr`+1, wrapping LAST_ADDR→FIRST_ADDR.
  - backward: `flash_addr`−1, wrapping FIRST_ADDR→LAST_ADDR.
  - Go to REQ if `play_en`=1, else IDLE.
- Pause (`play_en`=0):
  - In SAMP0/SAMP1, ticks are ignored and `audio_sample` holds.
  - In REQ, `fsm_stim` stays high until `read_done`; an in-flight handshake is never aborted.
  - No new REQ is entered.
- Direction changes take effect only at the next word latch. The half order within the current word never changes.
- Restart:
  - In IDLE/SAMP0/SAMP1/ADVANCE: `flash_addr` ← FIRST_ADDR (`direction`=1) or LAST_ADDR (`direction`=0); discard the latched word; go to REQ if `play_en`, else IDLE.
  - In REQ: restart is registered as pending. It is applied when `read_done` arrives, and that returned word is discarded.
- Simultaneous `restart` and `sample_tick`: restart wins; no `sample_valid`.
- Simultaneous `restart` and `read_done` in REQ: restart wins; the word is discarded and a new REQ is issued at the restart address.
- `sample_tick` in REQ or ADVANCE is dropped (underrun); `audio_sample` holds.

Optional Feature:
- Macro: FLASH_SEQ_TIMEOUT_EN.
- Defined:
  - A counter runs while in REQ.
  - If it reaches TIMEOUT_CYCLES without `read_done`: `fsm_stim`=0, `rd_timeout`=1 (sticky until reset), go to IDLE.
  - IDLE is not left while `rd_timeout`=1.
- Undefined: no counter, no `rd_timeout` port; REQ waits indefinitely.

Decomposition:
- Package `flash_seq_pkg` holds:
  - the state enum (IDLE, REQ, SAMP0, SAMP1, ADVANCE);
  - the ADDR_W default and the FIRST_ADDR/LAST_ADDR defaults;
  - `sample_t` (16-bit signed).
- One sub-module, `addr_wrap_counter`: loadable up/down counter with inclusive wrap bounds, driven by an enable, direction, and load-first/load-last controls.

Test Plan:
- Forward play: `play_en`=1, `direction`=1, `read_done` with `flash_data`=32'hBBBB_AAAA → `fsm_stim` drops the next cycle; two ticks give `audio_sample` 16'hAAAA then 16'hBBBB, each `sample_valid` one cycle after its tick; `flash_addr` 0→1; `fsm_stim` reasserts.
- Backward wrap: `direction`=0, restart → `flash_addr`=LAST_ADDR; word 32'h1234_5678 gives samples 16'h1234 then 16'h5678; at FIRST_ADDR the advance wraps to LAST_ADDR.
- Pause mid-word: `play_en`=0 after SAMP0 output → ticks produce no `sample_valid` and `audio_sample` holds; `play_en`=1 → next tick outputs the second half.
- Restart during REQ: `restart` pulse while `fsm_stim`=1 → `fsm_stim` stays high until `read_done`; that word is never output; a new REQ starts at FIRST_ADDR.
- Reset mid-REQ: `reset` for 1 cycle while `fsm_stim`=1 → next edge `fsm_stim`=0, `flash_addr`=0, `audio_sample`=0.
- Timeout (FLASH_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16): no `read_done` → after 16 cycles `fsm_stim`=0 and `rd_timeout`=1; it stays 1 with `play_en`=1 until reset.
